echo_receiver: RTL and testbench

ECHO_RECEIVER -- requirements
Module: echo_receiver

---
 rtl/echo_rx_pkg.sv | 17 +
 rtl/echo_sync_debounce.sv | 57 +++++
 rtl/echo_receiver.sv | 124 ++++++++++++
 tb/tb_echo_receiver.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_rx_pkg.sv
// rtl/echo_rx_pkg.sv - shared state encoding and default constants for the echo receiver
// Contents: rx_state_e (IDLE/BLANK/LISTEN/DONE) and the default parameter values.
package echo_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_LISTEN = 2'd2,
        ST_DONE   = 2'd3
    } rx_state_e;

    localparam int DEF_CNT_W          = 22;
    localparam int DEF_BLANK_CYCLES   = 25000;     // 0.5 ms at 50 MHz
    localparam int DEF_TIMEOUT_CYCLES = 1900000;   // 38 ms at 50 MHz
    localparam int DEF_DEBOUNCE       = 4;

endpackage

// File: rtl/echo_sync_debounce.sv
// rtl/echo_sync_debounce.sv - 2-flop synchronizer plus armed debounce for the active-low echo input
// Ports: gclk, rstn (async, active-low), out_4 (async echo, active-low),
//        clear (hold debounce idle), arm (listening window open), detect (echo confirmed this cycle).
module echo_sync_debounce
    import echo_rx_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic gclk,
    input  logic rstn,
    input  logic out_4,
    input  logic clear,
    input  logic arm,
    output logic detect
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic [1:0]      sync_q;     // sync_q[1] is the only bit safe to use
    logic            armed_q;    // a high (inactive) sample has been seen in this window
    logic [DB_W-1:0] db_cnt_q;   // consecutive low samples counted so far
    logic            echo_low;

    assign echo_low = ~sync_q[1];

    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], out_4};
        end
    end

    // Lows only count once armed, so a comparator still low from ringdown
    // must first go inactive before any echo can be reported.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            armed_q  <= 1'b0;
            db_cnt_q <= '0;
        end else if (clear) begin
            armed_q  <= 1'b0;
            db_cnt_q <= '0;
        end else if (arm) begin
            if (!echo_low) begin
                armed_q  <= 1'b1;
                db_cnt_q <= '0;
            end else if (armed_q && (db_cnt_q != DB_LAST)) begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    // The DEBOUNCE-th low sample is the current one, so detect is combinational.
    assign detect = arm & armed_q & echo_low & (db_cnt_q == DB_LAST);

endmodule

// File: rtl/echo_receiver.sv
// rtl/echo_receiver.sv - ultrasonic echo time-of-flight receiver with blanking, debounce and timeout
// Ports: gclk, rstn (async, active-low), measure_en, burst_finish (time-zero pulse),
//        out_4 (async echo, active-low), tof_count, tof_valid, timeout, busy.
module echo_receiver
    import echo_rx_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int DEBOUNCE       = DEF_DEBOUNCE
) (
    input  logic             gclk,
    input  logic             rstn,
    input  logic             measure_en,
    input  logic             burst_finish,
    input  logic             out_4,
    output logic [CNT_W-1:0] tof_count,
    output logic             tof_valid,
    output logic             timeout,
    output logic             busy
);

    // Transitions fire on the last cycle before the counter reaches the limit,
    // so the counter and the state change together on the same edge.
    localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // Detection trails the echo edge by 2 sync stages plus DEBOUNCE-1 extra samples.
    localparam logic [CNT_W-1:0] TOF_COMP     = CNT_W'(DEBOUNCE + 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;     // index of the current cycle, burst_finish cycle being 0
    logic [CNT_W-1:0] tof_q;
    logic             hit_q;     // DONE was reached by detection rather than timeout
    logic             listening;
    logic             restart;
    logic             finish;
    logic             detect;

    assign listening = (state_q == ST_LISTEN);
    assign restart   = measure_en & burst_finish & (state_q != ST_DONE);
    assign finish    = listening & (state_d == ST_DONE);

    echo_sync_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_sync_debounce (
        .gclk   (gclk),
        .rstn   (rstn),
        .out_4  (out_4),
        .clear  (~listening),
        .arm    (listening),
        .detect (detect)
    );

    // State register
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort by burst_finish outranks detection and timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (restart) state_d = ST_BLANK;
            end
            ST_BLANK: begin
                if (!measure_en)              state_d = ST_IDLE;
                else if (burst_finish)        state_d = ST_BLANK;
                else if (cnt_q == BLANK_LAST) state_d = ST_LISTEN;
            end
            ST_LISTEN: begin
                if (!measure_en)                          state_d = ST_IDLE;
                else if (burst_finish)                    state_d = ST_BLANK;
                else if (detect || cnt_q == TIMEOUT_LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter and result registers. The counter stops in DONE at TIMEOUT_CYCLES
    // at most, so it never wraps.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            tof_q <= '0;
            hit_q <= 1'b0;
        end else begin
            if (restart) begin
                cnt_q <= CNT_W'(1);
            end else if (state_q == ST_BLANK || state_q == ST_LISTEN) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (finish) begin
                hit_q <= detect;
                if (detect) tof_q <= cnt_q - TOF_COMP;
            end
        end
    end

    // Output logic
    always_comb begin
        busy      = 1'b0;
        tof_valid = 1'b0;
        timeout   = 1'b0;
        unique case (state_q)
            ST_BLANK, ST_LISTEN: busy = 1'b1;
            ST_DONE: begin
                tof_valid = hit_q;
                timeout   = ~hit_q;
            end
            default: ;
        endcase
    end

    assign tof_count = tof_q;

endmodule

// File: tb/tb_echo_receiver.sv
// tb/tb_echo_receiver.sv - self-checking bench for echo_receiver against a behavioural model
module tb_echo_receiver;

    localparam int CNT_W  = 12;
    localparam int BLANK  = 250;
    localparam int TMO    = 2000;
    localparam int DEB    = 4;
    localparam int MAXLEN = 4096;

    logic             gclk         = 1'b0;
    logic             rstn         = 1'b0;
    logic             measure_en   = 1'b0;
    logic             burst_finish = 1'b0;
    logic             out_4        = 1'b1;
    logic [CNT_W-1:0] tof_count;
    logic             tof_valid;
    logic             timeout;
    logic             busy;

    echo_receiver #(
        .CNT_W          (CNT_W),
        .BLANK_CYCLES   (BLANK),
        .TIMEOUT_CYCLES (TMO),
        .DEBOUNCE       (DEB)
    ) dut (
        .gclk         (gclk),
        .rstn         (rstn),
        .measure_en   (measure_en),
        .burst_finish (burst_finish),
        .out_4        (out_4),
        .tof_count    (tof_count),
        .tof_valid    (tof_valid),
        .timeout      (timeout),
        .busy         (busy)
    );

    always #5 gclk = ~gclk;

    int checks   = 0;
    int failures = 0;

    // Stimulus per cycle of a window and the expected outputs during that cycle
    bit w_stim  [MAXLEN];
    bit bf_stim [MAXLEN];
    bit en_stim [MAXLEN];
    bit exp_busy  [MAXLEN];
    bit exp_valid [MAXLEN];
    bit exp_to    [MAXLEN];
    int exp_tof   [MAXLEN];
    int held_tof = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    task automatic check_int(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    always @(negedge gclk) begin
        if (chk_on) begin
            checks++;
            if (busy !== exp_busy[cyc] || tof_valid !== exp_valid[cyc] ||
                timeout !== exp_to[cyc] || tof_count !== CNT_W'(exp_tof[cyc])) begin
                failures++;
                $display("FAIL cycle_check c=%0d got busy=%b valid=%b timeout=%b tof=%0d want busy=%b valid=%b timeout=%b tof=%0d",
                         cyc, busy, tof_valid, timeout, tof_count,
                         exp_busy[cyc], exp_valid[cyc], exp_to[cyc], exp_tof[cyc]);
            end
        end
    end

    // The synchronized level seen in cycle n is what was driven in cycle n-2.
    // An echo is confirmed at cycle c when the DEB samples ending at c are low
    // and the sample just before them is high.
    function automatic bit echo_seen(input int c);
        if (!w_stim[c - DEB - 2]) return 1'b0;
        for (int i = c - DEB + 1; i <= c; i++) begin
            if (w_stim[i - 2]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // mode 0: idle, 1: measuring since cycle st, 2: reporting a result this cycle
    task automatic build_model(input int len);
        int mode;
        int st;
        int r;
        int tof;
        int new_tof;
        bit hit;
        mode = 0; st = 0; tof = held_tof; new_tof = 0; hit = 1'b0;
        for (int c = 0; c < len; c++) begin
            exp_busy[c]  = (mode == 1);
            exp_valid[c] = (mode == 2) && hit;
            exp_to[c]    = (mode == 2) && !hit;
            if (mode == 2 && hit) tof = new_tof;
            exp_tof[c] = tof;
            r = c - st;
            if (mode == 0) begin
                if (en_stim[c] && bf_stim[c]) begin
                    mode = 1;
                    st   = c;
                end
            end else if (mode == 2) begin
                mode = 0;
            end else if (!en_stim[c]) begin
                mode = 0;
            end else if (bf_stim[c]) begin
                st = c;
            end else if (r - DEB >= BLANK && echo_seen(c)) begin
                mode    = 2;
                hit     = 1'b1;
                new_tof = r - 1 - DEB;
            end else if (r == TMO - 1) begin
                mode = 2;
                hit  = 1'b0;
            end
        end
        held_tof = tof;
    endtask

    function automatic int first_idx(input int len, input bit want_valid);
        for (int c = 0; c < len; c++) begin
            if (want_valid ? exp_valid[c] : exp_to[c]) return c;
        end
        return -1;
    endfunction

    function automatic int pulse_total(input int len);
        int n;
        n = 0;
        for (int c = 0; c < len; c++) n += int'(exp_valid[c]) + int'(exp_to[c]);
        return n;
    endfunction

    task automatic clear_stim(input int len);
        for (int c = 0; c < len; c++) begin
            w_stim[c]  = 1'b1;
            bf_stim[c] = 1'b0;
            en_stim[c] = 1'b1;
        end
    endtask

    task automatic set_w(input int from, input int to, input bit v);
        for (int c = from; c <= to; c++) w_stim[c] = v;
    endtask

    // Entered and left at 1 time unit after a rising edge
    task automatic run_window(input int len);
        chk_on = 1'b1;
        for (int c = 0; c < len; c++) begin
            cyc          = c;
            burst_finish = bf_stim[c];
            measure_en   = en_stim[c];
            out_4        = w_stim[c];
            @(posedge gclk);
            #1;
        end
        chk_on       = 1'b0;
        burst_finish = 1'b0;
    endtask

    task automatic directed(input string name, input int len, input int want_cyc,
                            input bit want_valid, input int want_tof);
        build_model(len);
        check_int({name, "_model_pulse_cycle"}, first_idx(len, want_valid), want_cyc);
        check_int({name, "_model_pulse_count"}, pulse_total(len), 1);
        run_window(len);
        check_int({name, "_tof_count"}, tof_count, want_tof);
    endtask

    initial begin
        int extra;
        int len;
        int a;
        int k;
        int c;
        int seg;
        bit lvl;

        rstn = 1'b0;
        repeat (3) @(posedge gclk);
        #1;
        check_int("reset_busy", busy, 0);
        check_int("reset_valid", tof_valid, 0);
        check_int("reset_timeout", timeout, 0);
        check_int("reset_tof", tof_count, 0);
        rstn = 1'b1;
        measure_en = 1'b1;
        @(posedge gclk);
        #1;

        // Echo at 300 held; burst_finish during DONE is ignored
        clear_stim(330); bf_stim[0] = 1'b1; bf_stim[306] = 1'b1; set_w(300, 329, 1'b0);
        directed("basic", 330, 306, 1'b1, 300);

        // Ringdown low through BLANK, must go inactive before the real echo
        clear_stim(430); bf_stim[0] = 1'b1; set_w(0, 260, 1'b0); set_w(400, 429, 1'b0);
        directed("ringdown", 430, 406, 1'b1, 400);

        // 3-cycle glitches are rejected
        clear_stim(530); bf_stim[0] = 1'b1;
        set_w(300, 302, 1'b0); set_w(310, 312, 1'b0); set_w(500, 529, 1'b0);
        directed("glitch", 530, 506, 1'b1, 500);

        // No echo: timeout, tof_count keeps previous result
        clear_stim(TMO + 20); bf_stim[0] = 1'b1;
        directed("timeout", TMO + 20, TMO, 1'b0, 500);

        // Restart during BLANK
        clear_stim(480); bf_stim[0] = 1'b1; bf_stim[100] = 1'b1; set_w(450, 479, 1'b0);
        directed("abort_blank", 480, 456, 1'b1, 350);

        // Restart in LISTEN one cycle before a detection would land
        clear_stim(570); bf_stim[0] = 1'b1; bf_stim[284] = 1'b1;
        set_w(280, 290, 1'b0); set_w(544, 569, 1'b0);
        directed("abort_listen", 570, 550, 1'b1, 260);

        // measure_en drop suppresses an imminent detection
        clear_stim(630); bf_stim[0] = 1'b1; bf_stim[300] = 1'b1;
        set_w(286, 599, 1'b0); set_w(610, 629, 1'b0);
        for (int i = 290; i <= 292; i++) en_stim[i] = 1'b0;
        directed("enable_drop", 630, 616, 1'b1, 310);

        // Detection on the last listening cycle beats timeout
        clear_stim(TMO + 20); bf_stim[0] = 1'b1; set_w(TMO - 6, TMO + 19, 1'b0);
        directed("edge_detect", TMO + 20, TMO, 1'b1, TMO - 6);

        // One cycle later the echo is too late
        clear_stim(TMO + 20); bf_stim[0] = 1'b1; set_w(TMO - 5, TMO + 19, 1'b0);
        directed("edge_timeout", TMO + 20, TMO, 1'b0, TMO - 6);

        // Reset in the middle of LISTEN
        clear_stim(280); bf_stim[0] = 1'b1;
        build_model(280);
        run_window(280);
        rstn = 1'b0;
        #1;
        check_int("midrst_busy", busy, 0);
        check_int("midrst_valid", tof_valid, 0);
        check_int("midrst_timeout", timeout, 0);
        check_int("midrst_tof", tof_count, 0);
        repeat (4) @(posedge gclk);
        #1;
        rstn = 1'b1;
        held_tof = 0;
        clear_stim(400);
        for (int i = 0; i < 400; i++) w_stim[i] = (i % 37) < 20;
        build_model(400);
        check_int("postrst_model_pulses", pulse_total(400), 0);
        run_window(400);
        clear_stim(330); bf_stim[0] = 1'b1; set_w(300, 329, 1'b0);
        directed("postrst", 330, 306, 1'b1, 300);

        // Randomized windows
        for (int n = 0; n < 12; n++) begin
            extra = -1;
            if ($urandom_range(0, 1) == 1) extra = $urandom_range(3, 1500);
            len = ((extra > 2) ? extra : 2) + TMO + 12;
            clear_stim(len);
            bf_stim[2] = 1'b1;
            if (extra > 0) bf_stim[extra] = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom_range(3, 1500);
                k = $urandom_range(1, 20);
                for (int i = a; i < a + k; i++) en_stim[i] = 1'b0;
            end
            lvl = 1'b1;
            if ($urandom_range(0, 2) == 0) lvl = 1'b0;
            c = 0;
            while (c < len) begin
                seg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DEB + 1)
                                                  : $urandom_range(20, 700);
                for (int i = 0; i < seg && c < len; i++) begin
                    w_stim[c] = lvl;
                    c++;
                end
                lvl = ~lvl;
            end
            build_model(len);
            run_window(len);
            check_int("random_tof_end", tof_count, held_tof);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
